// File: rtl/axis_vec_packer_pkg.sv
// Shared constants and types for the int8 -> 8-lane AXI-Stream vector packer.
package axis_vec_pkg;

  localparam int LANES  = 8;
  localparam int ELEM_W = 8;

  typedef logic [$clog2(LANES)-1:0]  lane_idx_t;
  typedef logic [15:0]               beat_t;
  typedef logic [LANES*ELEM_W-1:0]   vec_t;

  // Contiguous lane-valid mask covering lanes 0..last_lane.
  function automatic logic [LANES-1:0] keep_mask(lane_idx_t last_lane);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) m[k] = (k <= int'(last_lane));
    return m;
  endfunction

endpackage

// File: rtl/axis_vec_packer_if.sv
// Packed-vector output stream: 8 int8 lanes with keep/last/user sideband.
interface axis_vec_packer_if;
  import axis_vec_pkg::*;

  vec_t             tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [LANES-1:0] tkeep;
  logic             tuser;

  modport master (output tdata, tvalid, tlast, tkeep, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/axis_vec_packer_out_reg.sv
// Output holding register with valid/ready handshake for the vector packer.
// AXIS_VEC_PACKER_SOF_EN adds the registered start-of-vector (tuser) flag.
module axis_out_reg
  import axis_vec_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  vec_t             load_data,
  input  logic [LANES-1:0] load_keep,
  input  logic             load_last,
`ifdef AXIS_VEC_PACKER_SOF_EN
  input  logic             load_user,
`endif
  output logic             can_load,
  axis_vec_packer_if.master out
);

  vec_t             data_p1;
  logic [LANES-1:0] keep_p1;
  logic             last_p1;
  logic             vld_p1;

  // Stage p1: beat held here until the consumer takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
      keep_p1 <= load_keep;
      last_p1 <= load_last;
    end else if (out.tready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef AXIS_VEC_PACKER_SOF_EN
  logic user_p1;

  always_ff @(posedge clock) begin
    if (reset)     user_p1 <= 1'b0;
    else if (load) user_p1 <= load_user;
  end

  assign out.tuser = user_p1;
`else
  assign out.tuser = 1'b0;
`endif

  assign out.tdata  = data_p1;
  assign out.tkeep  = keep_p1;
  assign out.tlast  = last_p1;
  assign out.tvalid = vld_p1;
  assign can_load   = !vld_p1 || out.tready;

endmodule

// File: rtl/axis_vec_packer.sv
// Packs a stream of signed int8 elements into 8-lane beats, forcing a tlast
// after MAX_VEC_BEATS beats. AXIS_VEC_PACKER_SOF_EN enables the tuser SOF flag.
module axis_vec_packer
  import axis_vec_pkg::*;
#(
  parameter int MAX_VEC_BEATS = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [ELEM_W-1:0] io_in_tdata,
  input  logic                     io_in_tvalid,
  output logic                     io_in_tready,
  input  logic                     io_in_tlast,
  output logic [LANES*ELEM_W-1:0]  io_out_tdata,
  output logic                     io_out_tvalid,
  input  logic                     io_out_tready,
  output logic                     io_out_tlast,
  output logic [LANES-1:0]         io_out_tkeep,
  output logic                     io_out_tuser,
  output logic                     io_vec_split
);

  localparam int    BEAT_W    = $clog2(MAX_VEC_BEATS);
  localparam beat_t LAST_BEAT = beat_t'(MAX_VEC_BEATS - 1);

  axis_vec_packer_if out_bus ();

  lane_idx_t        lane_idx;
  vec_t             asm_p0;
  logic [BEAT_W-1:0] beat_cnt;
  logic             split_p1;
  logic             can_load, accept, full, beat_done, forced, beat_last;
  vec_t             beat_data;
  logic [LANES-1:0] beat_keep;

  // Lanes above lane_idx are always zero in asm_p0, so the merged beat
  // already carries zeroed unfilled lanes.
  always_comb begin
    accept    = io_in_tvalid && can_load;
    full      = (lane_idx == lane_idx_t'(LANES - 1));
    beat_done = accept && (full || io_in_tlast);
    forced    = full && !io_in_tlast && (beat_t'(beat_cnt) == LAST_BEAT);
    beat_last = io_in_tlast || forced;
    beat_data = asm_p0;
    beat_data[lane_idx*ELEM_W +: ELEM_W] = io_in_tdata;
    beat_keep = keep_mask(lane_idx);
  end

  // Stage p0: lane assembly and per-vector beat counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      lane_idx <= '0;
      asm_p0   <= '0;
      beat_cnt <= '0;
      split_p1 <= 1'b0;
    end else begin
      split_p1 <= beat_done && forced;
      if (beat_done) begin
        lane_idx <= '0;
        asm_p0   <= '0;
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      end else if (accept) begin
        lane_idx <= lane_idx + 1'b1;
        asm_p0   <= beat_data;
      end
    end
  end

`ifdef AXIS_VEC_PACKER_SOF_EN
  logic sof_p0;

  always_ff @(posedge clock) begin
    if (reset)          sof_p0 <= 1'b1;
    else if (beat_done) sof_p0 <= beat_last;
  end
`endif

  axis_out_reg u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (beat_done),
    .load_data (beat_data),
    .load_keep (beat_keep),
    .load_last (beat_last),
`ifdef AXIS_VEC_PACKER_SOF_EN
    .load_user (sof_p0),
`endif
    .can_load  (can_load),
    .out       (out_bus.master)
  );

  assign out_bus.tready = io_out_tready;
  assign io_in_tready   = can_load;
  assign io_out_tdata   = out_bus.tdata;
  assign io_out_tvalid  = out_bus.tvalid;
  assign io_out_tlast   = out_bus.tlast;
  assign io_out_tkeep   = out_bus.tkeep;
  assign io_out_tuser   = out_bus.tuser;
  assign io_vec_split   = split_p1;

endmodule
